// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM state
// encoding, event channel indices and the default counter width.
package perf_pkg;

  // Measurement window controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_e;

  // Event channel assignment as wired from the hazard unit and IF/ID stage
  localparam int EVT_STALL   = 0;
  localparam int EVT_FLUSH   = 1;
  localparam int EVT_BRANCH  = 2;
  localparam int EVT_LOADUSE = 3;

  localparam int PERF_CNT_W_DEFAULT = 32;

endpackage : perf_pkg

// File: rtl/perf_counter.sv
// Single performance counter with synchronous clear, increment strobe and a
// sticky overflow flag. Wraps at 2**CNT_W by default; with PERF_SATURATE_EN
// defined it saturates at all-ones and flags the first blocked increment.
// cnt_nxt_o exposes the value the counter takes at the coming edge so the
// read port can register post-update data without an extra cycle.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             at_max_s;

  assign at_max_s = (cnt_q == {CNT_W{1'b1}});

  // Next-state: clear wins, otherwise step on inc with wrap or saturation
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else if (inc_i) begin
`ifdef PERF_SATURATE_EN
      if (at_max_s) begin
        cnt_d = cnt_q;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q;
      end
`else
      cnt_d = cnt_q + CNT_W'(1);
      if (at_max_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
`endif
    end else begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
    end
  end

  // Counter and sticky overflow registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= {CNT_W{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign ovf_o     = ovf_q;

endmodule : perf_counter

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: counts RUN cycles and per-channel event
// strobes over a bounded window (limit 0 = unbounded). start_i pauses and
// resumes without clearing; clear_i zeroes everything and returns to IDLE.
// Optional build macro: PERF_SATURATE_EN (saturating instead of wrapping
// counters, handled inside perf_counter).
// Read select must satisfy 2**SEL_W > NUM_EVT so the cycle counter is
// addressable at index NUM_EVT.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = PERF_CNT_W_DEFAULT,
  parameter int SEL_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  perf_state_e      state_q;
  perf_state_e      state_d;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] limit_d;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_data_d;

  // Index NUM_EVT is the cycle counter, 0..NUM_EVT-1 are event channels
  logic [CNT_W-1:0] cnt_s     [NUM_EVT+1];
  logic [CNT_W-1:0] cnt_nxt_s [NUM_EVT+1];
  logic [NUM_EVT:0] ovf_s;
  logic [NUM_EVT:0] inc_s;
  logic             count_en_s;
  logic [CNT_W-1:0] cyc_plus1_s;
  logic             win_end_s;

  // Counting happens only in RUN and never in a clearing cycle
  assign count_en_s  = (state_q == RUN) && !clear_i;
  assign cyc_plus1_s = cnt_s[NUM_EVT] + CNT_W'(1);
  // The last cycle of a bounded window is the one that makes the cycle
  // counter equal the latched limit; its increments still apply
  assign win_end_s   = (limit_q != {CNT_W{1'b0}}) && (cyc_plus1_s == limit_q);

  // Increment strobes for every counter instance
  always_comb begin
    inc_s = {count_en_s, evt_i & {NUM_EVT{count_en_s}}};
  end

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (clear_i),
      .inc_i     (inc_s[k]),
      .cnt_o     (cnt_s[k]),
      .cnt_nxt_o (cnt_nxt_s[k]),
      .ovf_o     (ovf_s[k])
    );
  end

  // FSM next-state and limit latch; clear has priority in every state,
  // window end has priority over a pause request in RUN
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    if (clear_i) begin
      state_d = IDLE;
      limit_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            limit_d = limit_i;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (win_end_s) begin
            state_d = DONE;
          end else if (!start_i) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          limit_d = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Read mux over post-update counter values; out-of-range selects read 0
  always_comb begin
    rd_data_d = {CNT_W{1'b0}};
    for (int k = 0; k <= NUM_EVT; k++) begin
      rd_data_d = (rd_sel_i == SEL_W'(k)) ? cnt_nxt_s[k] : rd_data_d;
    end
  end

  // FSM state, latched window limit and registered read data
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      limit_q   <= {CNT_W{1'b0}};
      rd_data_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign ovf_o     = ovf_s;

endmodule : pipe_perf_monitor

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor (NUM_EVT=4, CNT_W=6, SEL_W=3).
// A behavioural model built on plain integer arithmetic tracks the expected
// counters, flags and mode; directed steps cover the named scenarios and a
// randomized phase follows. Honours PERF_SATURATE_EN when defined.
module tb_pipe_perf_monitor;

  localparam int  NEV  = 4;
  localparam int  CW   = 6;
  localparam int  SW   = 3;
  localparam longint MOD = 64;   // 2**CW

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           clear;
  logic [NEV-1:0] evt;
  logic [CW-1:0]  limit;
  logic [SW-1:0]  rd_sel;
  logic [CW-1:0]  rd_data;
  logic           running;
  logic           done;
  logic [NEV:0]   ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 run, 2 done
  int          m_mode;
  longint      m_cnt [NEV+1];
  logic [NEV:0] m_ovf;
  longint      m_lim;
  longint      m_rd;

  logic [CW-1:0] rd_obs [8];

  pipe_perf_monitor #(
    .NUM_EVT (NEV),
    .CNT_W   (CW),
    .SEL_W   (SW)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .clear_i   (clear),
    .evt_i     (evt),
    .limit_i   (limit),
    .rd_sel_i  (rd_sel),
    .rd_data_o (rd_data),
    .running_o (running),
    .done_o    (done),
    .ovf_o     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    for (int k = 0; k <= NEV; k++) m_cnt[k] = 0;
    m_ovf = '0;
    m_lim = 0;
    m_rd  = 0;
  endtask

  task automatic bump(input int k);
`ifdef PERF_SATURATE_EN
    if (m_cnt[k] == MOD - 1) m_ovf[k] = 1'b1;
    else m_cnt[k] = m_cnt[k] + 1;
`else
    m_cnt[k] = (m_cnt[k] + 1) % MOD;
    if (m_cnt[k] == 0) m_ovf[k] = 1'b1;
`endif
  endtask

  // Apply the rules of one clock edge using the inputs presented to it
  task automatic model_step();
    longint prev;
    if (clear) begin
      for (int k = 0; k <= NEV; k++) m_cnt[k] = 0;
      m_ovf  = '0;
      m_lim  = 0;
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_lim  = limit;
      end
    end else if (m_mode == 1) begin
      prev = m_cnt[NEV];
      bump(NEV);
      for (int k = 0; k < NEV; k++) if (evt[k]) bump(k);
      if (m_lim != 0 && ((prev + 1) % MOD) == m_lim) m_mode = 2;
      else if (!start) m_mode = 0;
    end
    m_rd = (rd_sel <= NEV) ? m_cnt[rd_sel] : 0;
  endtask

  task automatic check_outputs();
    chk("running", running, (m_mode == 1));
    chk("done", done, (m_mode == 2));
    chk("ovf", ovf, m_ovf);
    chk("rd_data", rd_data, m_rd);
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic sweep();
    for (int s = 0; s < 8; s++) begin
      rd_sel = s[SW-1:0];
      cyc();
      rd_obs[s] = rd_data;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; evt = '0; limit = '0; rd_sel = '0;
    model_reset();
    #3;
    chk("reset_running", running, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ovf", ovf, 5'd0);
    chk("reset_rd", rd_data, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bounded window of 30 with channel 0 active in RUN cycles 3..7
    limit = 6'd30; start = 1'b1; rd_sel = 3'd4;
    cyc();
    for (int i = 1; i <= 32; i++) begin
      evt = (i >= 3 && i <= 7) ? 4'b0001 : 4'b0000;
      cyc();
    end
    evt = 4'b0000;
    chk("win_done", done, 1'b1);
    chk("win_running", running, 1'b0);
    sweep();
    chk("win_ch0", rd_obs[0], 6'd5);
    chk("win_ch1", rd_obs[1], 6'd0);
    chk("win_ch3", rd_obs[3], 6'd0);
    chk("win_cycles", rd_obs[4], 6'd30);
    chk("sel5_zero", rd_obs[5], 6'd0);
    chk("sel7_zero", rd_obs[7], 6'd0);

    // Pause and resume with unlimited window
    clear = 1'b1; start = 1'b0;
    cyc();
    clear = 1'b0; limit = 6'd0; start = 1'b1; rd_sel = 3'd4;
    cyc();
    repeat (9) begin
      evt = 4'($urandom);
      cyc();
    end
    start = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      evt = 4'($urandom);
      cyc();
      chk("pause_hold", rd_data, 6'd10);
    end
    start = 1'b1;
    cyc();
    repeat (10) begin
      evt = 4'($urandom);
      cyc();
    end
    chk("resume_cycles", rd_data, 6'd20);
    chk("resume_running", running, 1'b1);

    // Channel 1 held for 65 RUN cycles: wraps (or saturates) past 63
    clear = 1'b1; start = 1'b0; evt = 4'b0000;
    cyc();
    clear = 1'b0; start = 1'b1; limit = 6'd0; rd_sel = 3'd1;
    cyc();
    evt = 4'b0010;
    repeat (65) cyc();
`ifdef PERF_SATURATE_EN
    chk("ovf_ch1_value", rd_data, 6'd63);
`else
    chk("ovf_ch1_value", rd_data, 6'd1);
`endif
    chk("ovf_ch1_flag", ovf[1], 1'b1);
    chk("ovf_cycle_flag", ovf[4], 1'b1);

    // Clear in RUN together with all events: nothing counted, all zeroed
    evt = 4'b1111; clear = 1'b1; start = 1'b0;
    cyc();
    chk("clear_running", running, 1'b0);
    chk("clear_ovf", ovf, 5'd0);
    chk("clear_rd", rd_data, 6'd0);
    clear = 1'b0; evt = 4'b0000;
    sweep();
    chk("clear_ch3", rd_obs[3], 6'd0);
    chk("clear_cycles", rd_obs[4], 6'd0);

    // Asynchronous reset asserted in the 12th RUN cycle
    start = 1'b1; limit = 6'd0; rd_sel = 3'd4; evt = 4'b0101;
    cyc();
    repeat (11) cyc();
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_running", running, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_ovf", ovf, 5'd0);
    chk("arst_rd", rd_data, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    repeat (5) cyc();
    chk("restart_cycles", rd_data, 6'd5);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      start  = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 59) == 0);
      evt    = 4'($urandom);
      rd_sel = 3'($urandom_range(0, 7));
      limit  = 6'($urandom_range(0, 40));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_perf_monitor

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
Synthesizable performance monitor for the 5-stage pipelined CPU. It counts run cycles and per-channel pipeline events (stall, flush, branch, load-use) over a bounded measurement window. It replaces bench-side ad hoc counting with on-chip counters. Sits beside the CPU top, fed by qualified single-cycle event strobes from the hazard unit and IF/ID stage.

Parameters:
NUM_EVT, 4, number of event channels (index 0..NUM_EVT-1)
CNT_W, 32, width of each event counter and the cycle counter
SEL_W, 3, width of read-select; must satisfy 2**SEL_W > NUM_EVT

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  level; high = measurement enabled
clear_i  in  1  synchronous clear of all counters/flags, returns FSM to IDLE
evt_i  in  NUM_EVT  per-channel event strobe, one count per high cycle
limit_i  in  CNT_W  window length in cycles; 0 = unlimited; latched on IDLE->RUN
rd_sel_i  in  SEL_W  read select: 0..NUM_EVT-1 event counter, NUM_EVT cycle counter
rd_data_o  out  CNT_W  registered read data
running_o  out  1  FSM in RUN
done_o  out  1  FSM in DONE
ovf_o  out  NUM_EVT+1  sticky overflow per counter; MSB = cycle counter

Behaviour:
- Reset (rst_n_i low, async): FSM=IDLE, all counters 0, latched limit 0, rd_data_o 0, running_o 0, done_o 0, ovf_o 0.
- FSM states IDLE, RUN, DONE. clear_i has highest priority in every state: next state IDLE, counters/ovf/limit zeroed; events in that cycle are not counted.
- IDLE: counters hold. start_i=1 -> RUN next cycle, latch limit_i. No counting in the transition cycle.
- RUN: each cycle cycle counter +1; each event counter +1 where evt_i[k]=1. start_i=0 -> IDLE (pause; counts held, resume on next start_i without clearing; limit re-latched on resume).
- Window end: in RUN, if latched limit!=0 and cycle counter+1 == limit, that cycle's increments still apply and next state DONE. Thus cycle counter reads exactly limit in DONE.
- DONE: counters frozen, done_o=1. start_i ignored; only clear_i (or reset) leaves.
- Arithmetic: unsigned CNT_W. Default wrap at 2**CNT_W to 0; wrap sets the corresponding ovf_o bit (sticky until clear/reset).
- Read: rd_data_o updated every cycle from rd_sel_i, 1-cycle latency; reflects counter value after that edge's update. Select > NUM_EVT returns 0.
- running_o/done_o are decoded from registered state (no combinational path from inputs).
- Reset asserted mid-RUN: immediate return to reset values, no partial update.

Optional Feature:
PERF_SATURATE_EN: when defined, counters saturate at 2**CNT_W-1 instead of wrapping; ovf_o bit sets on the first attempted increment past max. Cycle counter saturation in RUN with limit 0 holds state RUN. When undefined, wrap behaviour as above.

Decomposition:
- Package perf_pkg: FSM state enum (IDLE, RUN, DONE), channel index constants EVT_STALL=0, EVT_FLUSH=1, EVT_BRANCH=2, EVT_LOADUSE=3, default CNT_W.
- Sub-module perf_counter (CNT_W): one counter with inc, clr, ovf sticky flag, saturation under PERF_SATURATE_EN; instantiated NUM_EVT+1 times.

Test Plan:
- Reset then start_i=1, limit_i=30, evt_i[0] high cycles 3-7 of RUN -> DONE after 30 RUN cycles, cycle cnt=30, ch0=5, others 0, done_o=1.
- Pause: limit 0, run 10 cycles, start_i low 5 cycles, high 10 more -> cycle cnt=20, counters unchanged during pause.
- clear_i same cycle as evt_i=4'b1111 in RUN -> all counters 0, FSM IDLE, ovf_o 0.
- CNT_W=4, evt_i[1] held 17 RUN cycles -> wrap: ch1=1, ovf_o[1]=1; with PERF_SATURATE_EN ch1=15, ovf_o[1]=1.
- Read port: rd_sel_i=4 -> rd_data_o equals cycle count one cycle later; rd_sel_i=7 -> 0.
- rst_n_i pulsed low mid-RUN (cycle 12) -> all outputs 0 asynchronously, FSM IDLE, restart counts from 0.
